// File: rtl/sym_sequencer.sv
// Memory-game sequencer: grows a random symbol sequence one entry per round,
// replays it on the display port, then checks the player's entries against it.
module sym_sequencer #(
    parameter int MAX_LEN     = 16,
    parameter int SHOW_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] rand_num,
    output logic       rand_en,
    input  logic       user_valid,
    input  logic [3:0] user_sym,
    output logic       show_valid,
    output logic [3:0] show_sym,
    output logic       busy,
    output logic [4:0] level,
    output logic       win,
    output logic       lose,
    output logic [2:0] state_dbg
);

    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

    localparam logic [PW-1:0] SHOW_LAST = PW'(SHOW_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
    localparam logic [4:0]    MAX_LEN_V = 5'(MAX_LEN);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADD   = 3'd1;
    localparam logic [2:0] SHOW  = 3'd2;
    localparam logic [2:0] INPUT = 3'd3;
    localparam logic [2:0] WIN   = 3'd4;
    localparam logic [2:0] LOSE  = 3'd5;

    logic [2:0]    state;
    logic [4:0]    len;
    logic [4:0]    idx;
    logic [PW-1:0] phase;
    logic          in_gap;
    logic [3:0]    mem [MAX_LEN];

    logic       last_idx;
    logic [3:0] cur_sym;

    assign last_idx = (idx == len - 5'd1);
    assign cur_sym  = mem[idx[IW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            len    <= 5'd0;
            idx    <= 5'd0;
            phase  <= '0;
            in_gap <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        state <= ADD;
                        len   <= 5'd0;
                    end
                end
                ADD: begin
                    len    <= len + 5'd1;
                    idx    <= 5'd0;
                    phase  <= '0;
                    in_gap <= 1'b0;
                    state  <= SHOW;
                end
                SHOW: begin
                    // Each element: SHOW_CYCLES lit, then GAP_CYCLES blank.
                    if (!in_gap) begin
                        if (phase == SHOW_LAST) begin
                            phase  <= '0;
                            in_gap <= 1'b1;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end else if (phase == GAP_LAST) begin
                        phase  <= '0;
                        in_gap <= 1'b0;
                        if (last_idx) begin
                            idx   <= 5'd0;
                            state <= INPUT;
                        end else begin
                            idx <= idx + 5'd1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                INPUT: begin
                    if (user_valid) begin
                        if (user_sym != cur_sym) begin
                            state <= LOSE;
                        end else if (!last_idx) begin
                            idx <= idx + 5'd1;
                        end else if (len == MAX_LEN_V) begin
                            state <= WIN;
                        end else begin
                            state <= ADD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // len < MAX_LEN whenever ADD is entered, so the write index stays in range.
    always_ff @(posedge clk) begin
        if (state == ADD) begin
            mem[len[IW-1:0]] <= rand_num;
        end
    end

    assign rand_en    = (state == ADD);
    assign show_valid = (state == SHOW) && !in_gap;
    assign show_sym   = show_valid ? cur_sym : 4'd0;
    assign busy       = (state == ADD) || (state == SHOW) || (state == INPUT);
    assign level      = len;
    assign win        = (state == WIN);
    assign lose       = (state == LOSE);
    assign state_dbg  = state;

endmodule
